logic_op_arbiter: RTL and testbench
===================================

// Module: logic_op_arbiter
// PURPOSE
//  Shares one bitwise logic-gate unit (AND/NAND/OR/NOR/XOR/XNOR/NOT) between N_REQ requesters.
//  Arbitration is round-robin. The block latches the winner's operands and opcode, runs them
//  through the gate unit, and returns a registered result tagged with the requester ID.
//  It sits between the requester masters and the combinational gate datapath.
// PARAMETERS
//  N_REQ  4  number of requesters (2..16)
//  WIDTH  8  operand/result width in bits; gate ops apply bitwise across all WIDTH bits
//  IDW    2  requester ID width, = clog2(N_REQ)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous reset, active high
//  req_valid  in   N_REQ      per-requester request valid
//  req_ready  out  N_REQ      per-requester accept; at most one bit high at a time
//  req_op     in   3*N_REQ    opcode, requester i at [3i+2:3i]
//  req_a      in   WIDTH*N_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
//  req_b      in   WIDTH*N_REQ  operand B, same packing as req_a
//  rsp_valid  out  1          result valid
//  rsp_ready  in   1          result consumer ready
//  rsp_id     out  IDW        index of the requester that owns rsp_y
//  rsp_y      out  WIDTH      result
//  rsp_err    out  1          set when the accepted opcode was reserved (7)
// BEHAVIOUR
//  Opcodes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (B ignored),
//   7 reserved -> rsp_y = 0, rsp_err = 1.
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0.
//  FSM states:
//   IDLE: winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
//    req_ready[winner]=1 combinationally in IDLE only; the handshake completes in this cycle.
//    On handshake, latch op/a/b/id and go to EXEC. If no req_valid, stay in IDLE.
//   EXEC: gate unit evaluates the latched operands. Register rsp_y, rsp_err and rsp_id.
//    Set rsp_valid=1 and go to RESP.
//   RESP: hold rsp_valid/rsp_y/rsp_id/rsp_err stable until rsp_ready=1.
//    On rsp_valid & rsp_ready: rsp_valid=0, rr_ptr = (id+1) mod N_REQ, go to IDLE.
//  Latency: request accepted at cycle T -> rsp_valid high at T+2. Min 3 cycles per op
//   when rsp_ready is held high.
//  req_ready is 0 in EXEC and RESP; new requests wait (no buffering).
//  Requesters hold valid, op and operands stable until ready. Dropping valid without ready
//   is allowed and causes no side effect.
//  Fairness: after requester k is served, k has lowest priority. Any requester holding
//   valid is served within N_REQ grants.
//  rr_ptr wraps N_REQ-1 -> 0. Non-power-of-two N_REQ: IDs >= N_REQ are never granted.
//  A latched request is independent of later req_* changes.
//  rsp_ready high while not in RESP has no effect.
//  rst mid-operation (EXEC or RESP): the transaction is dropped without a response and all
//   reset values apply on the next cycle.
// TESTING
//  1 Single req0, op=0 (AND), A=8'hF0, B=8'h3C, rsp_ready=1 -> ready pulse at T;
//    rsp_valid at T+2, rsp_y=8'h30, rsp_id=0, rsp_err=0.
//  2 Op sweep on req2, A=8'hA5, B=8'h0F, ops 0..7 -> y = 05, FA, AF, 50, AA, 55, 5A, 00.
//    rsp_err=1 only for op 7.
//  3 All 4 req_valid held from reset -> grant order 0,1,2,3,0,1...
//    req_ready is one-hot and 3 cycles apart.
//  4 rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y/rsp_id hold stable, all req_ready=0.
//    After rsp_ready=1, next grant 1 cycle later.
//  5 rst asserted in EXEC -> next cycle all outputs at reset values, rr_ptr=0,
//    no rsp_valid for the dropped op.
//  6 Only req3 valid, then req3+req0 -> req3 served first, then req0 (pointer wrap 3->0).

Source files
------------

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between N_REQ requesters and the shared logic-op unit.
// master = requester side, slave = arbiter side.
interface logic_op_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [3*N_REQ-1:0]     req_op;
   logic [WIDTH*N_REQ-1:0] req_a;
   logic [WIDTH*N_REQ-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [WIDTH-1:0]       rsp_y;
   logic                   rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_y, rsp_err
   );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise gate unit among N_REQ requesters;
// one request in flight at a time: IDLE grant -> EXEC compute -> RESP hold.
module logic_op_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic clk,
   input  logic rst,
   logic_op_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   cand;
   logic             found;
   logic             accept;
   logic [N_REQ-1:0] ready;

   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   logic [2:0]       lat_op;
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic [IDW-1:0]   lat_id;

   logic [WIDTH-1:0] gate_y;
   logic             gate_err;

   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] y_q;
   logic             err_q;

   // First valid requester at or after rr_ptr, wrapping at N_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % N_REQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign accept = (state == IDLE) && !rst && found;

   always_comb begin
      ready  = '0;
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win == IDW'(i)) begin
            ready[i] = accept;
            sel_op   = bus.req_op[3*i +: 3];
            sel_a    = bus.req_a[WIDTH*i +: WIDTH];
            sel_b    = bus.req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      gate_y   = '0;
      gate_err = 1'b0;
      unique case (lat_op)
         3'd0: gate_y = lat_a & lat_b;
         3'd1: gate_y = ~(lat_a & lat_b);
         3'd2: gate_y = lat_a | lat_b;
         3'd3: gate_y = ~(lat_a | lat_b);
         3'd4: gate_y = lat_a ^ lat_b;
         3'd5: gate_y = ~(lat_a ^ lat_b);
         3'd6: gate_y = ~lat_a;
         default: gate_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (found) state_nxt = EXEC;
         EXEC: state_nxt = RESP;
         RESP: if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         lat_op <= '0;
         lat_a  <= '0;
         lat_b  <= '0;
         lat_id <= '0;
         id_q   <= '0;
         y_q    <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            lat_op <= sel_op;
            lat_a  <= sel_a;
            lat_b  <= sel_b;
            lat_id <= win;
         end
         if (state == EXEC) begin
            y_q   <= gate_y;
            err_q <= gate_err;
            id_q  <= lat_id;
         end
         // Served requester drops to lowest priority.
         if (state == RESP && bus.rsp_ready) begin
            rr_ptr <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_y     = y_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter: grants push model results,
// accepted responses pop and compare; scenario tasks add inline checks.
module tb_logic_op_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] y;
      logic       err;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       rsp_rdy;
   logic [3:0] v_r;
   logic [2:0] op_r [4];
   logic [7:0] a_r  [4];
   logic [7:0] b_r  [4];

   logic [3:0] s_ready;
   logic       s_rv;
   logic [1:0] s_id;
   logic [7:0] s_y;
   logic       s_err;
   int         s_hs;

   int   tests;
   int   fails;
   int   cyc;
   int   grant_cyc;
   exp_t exp_q [$];

   logic_op_arbiter_if #(.N_REQ(4), .WIDTH(8), .IDW(2)) bus ();

   logic_op_arbiter #(.N_REQ(4), .WIDTH(8), .IDW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.req_valid = v_r;
   assign bus.rsp_ready = rsp_rdy;

   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign bus.req_op[3*g +: 3] = op_r[g];
      assign bus.req_a[8*g +: 8]  = a_r[g];
      assign bus.req_b[8*g +: 8]  = b_r[g];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [1:0] id, input logic [2:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
      exp_t m;
      m.id  = id;
      m.err = 1'b0;
      case (op)
         3'd0: m.y = a & b;
         3'd1: m.y = ~(a & b);
         3'd2: m.y = a | b;
         3'd3: m.y = ~(a | b);
         3'd4: m.y = a ^ b;
         3'd5: m.y = a ~^ b;
         3'd6: m.y = ~a;
         default: begin
            m.y   = 8'h00;
            m.err = 1'b1;
         end
      endcase
      return m;
   endfunction

   // Sample on the falling edge, then return just after the next rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      s_ready = bus.req_ready;
      s_rv    = bus.rsp_valid;
      s_id    = bus.rsp_id;
      s_y     = bus.rsp_y;
      s_err   = bus.rsp_err;
      s_hs    = -1;
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.req_ready[i[1:0]] && bus.req_valid[i[1:0]]) begin
               s_hs = i;
               exp_q.push_back(model(i[1:0], op_r[i[1:0]], a_r[i[1:0]], b_r[i[1:0]]));
               grant_cyc = cyc;
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL scoreboard: unexpected response id=%0d y=%h", s_id, s_y);
            end else begin
               e = exp_q.pop_front();
               if ({s_id, s_y, s_err} !== {e.id, e.y, e.err}) begin
                  fails++;
                  $display("FAIL scoreboard: got id=%0d y=%h err=%b, want id=%0d y=%h err=%b",
                           s_id, s_y, s_err, e.id, e.y, e.err);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int bound);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (s_hs < 0 && n < bound);
   endtask

   task automatic wait_rsp(input int bound);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!s_rv && n < bound);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 12) begin
         tick();
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
      end
   endtask

   task automatic set_req(input logic [1:0] i, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b);
      op_r[i] = op;
      a_r[i]  = a;
      b_r[i]  = b;
      v_r[i]  = 1'b1;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      rsp_rdy = 1'b0;
      v_r     = '0;
      repeat (3) tick();
      tests++;
      if ({s_ready, s_rv, s_id, s_y, s_err} !== 15'h0) begin
         fails++;
         $display("FAIL reset: ready=%b rv=%b id=%0d y=%h err=%b, want all 0",
                  s_ready, s_rv, s_id, s_y, s_err);
      end
      rst = 1'b0;
      tick();
      tests++;
      if (s_ready !== 4'b0 || s_rv !== 1'b0) begin
         fails++;
         $display("FAIL idle: ready=%b rv=%b, want 0000/0", s_ready, s_rv);
      end
   endtask

   task automatic test_single();
      int g;
      rsp_rdy = 1'b1;
      set_req(2'd0, 3'd0, 8'hF0, 8'h3C);
      wait_grant(8);
      g = grant_cyc;
      v_r = '0;
      tests++;
      if (s_hs != 0 || s_ready !== 4'b0001) begin
         fails++;
         $display("FAIL single_grant: id=%0d ready=%b, want 0/0001", s_hs, s_ready);
      end
      tick();
      tests++;
      if (s_rv !== 1'b0) begin
         fails++;
         $display("FAIL single_t1: rsp_valid=%b, want 0", s_rv);
      end
      tick();
      tests++;
      if (s_rv !== 1'b1 || cyc != g + 2 || s_y !== 8'h30 || s_id !== 2'd0 || s_err !== 1'b0) begin
         fails++;
         $display("FAIL single_rsp: rv=%b dt=%0d y=%h id=%0d err=%b, want 1/2/30/0/0",
                  s_rv, cyc - g, s_y, s_id, s_err);
      end
      tick();
      tests++;
      if (s_rv !== 1'b0) begin
         fails++;
         $display("FAIL single_done: rsp_valid=%b, want 0", s_rv);
      end
   endtask

   task automatic test_op_sweep();
      logic [7:0] ytab [8];
      ytab = '{8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'h00};
      rsp_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_req(2'd2, k[2:0], 8'hA5, 8'h0F);
         wait_grant(8);
         v_r = '0;
         tests++;
         if (s_hs != 2) begin
            fails++;
            $display("FAIL sweep_grant op=%0d: id=%0d, want 2", k, s_hs);
         end
         wait_rsp(8);
         tests++;
         if (s_rv !== 1'b1 || s_y !== ytab[k] || s_err !== (k == 7)) begin
            fails++;
            $display("FAIL sweep op=%0d: rv=%b y=%h err=%b, want 1/%h/%b",
                     k, s_rv, s_y, s_err, ytab[k], (k == 7));
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_id;
      int prev;
      int nseen;
      rst = 1'b1;
      exp_q.delete();
      rsp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(i[1:0], i[2:0], 8'(8'h11 * (i + 1)), 8'h0F);
      end
      repeat (2) tick();
      rst    = 1'b0;
      exp_id = 0;
      prev   = -1;
      nseen  = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (s_ready != 4'b0) begin
            tests++;
            if (!$onehot(s_ready) || s_hs != exp_id) begin
               fails++;
               $display("FAIL rr_grant #%0d: ready=%b id=%0d, want id %0d one-hot",
                        nseen, s_ready, s_hs, exp_id);
            end
            if (prev >= 0) begin
               tests++;
               if (cyc - prev != 3) begin
                  fails++;
                  $display("FAIL rr_spacing #%0d: gap=%0d, want 3", nseen, cyc - prev);
               end
            end
            prev   = cyc;
            exp_id = (exp_id + 1) % 4;
            nseen++;
         end
      end
      tests++;
      if (nseen < 6) begin
         fails++;
         $display("FAIL rr_count: %0d grants, want >= 6", nseen);
      end
      v_r = '0;
      drain();
   endtask

   task automatic test_backpressure();
      logic [7:0] hy;
      logic [1:0] hid;
      rsp_rdy = 1'b0;
      set_req(2'd1, 3'd4, 8'h3C, 8'hFF);
      wait_grant(8);
      v_r = '0;
      wait_rsp(8);
      hy  = s_y;
      hid = s_id;
      tests++;
      if (s_rv !== 1'b1 || hy !== 8'hC3 || hid !== 2'd1) begin
         fails++;
         $display("FAIL bp_first: rv=%b y=%h id=%0d, want 1/c3/1", s_rv, hy, hid);
      end
      set_req(2'd0, 3'd2, 8'h01, 8'h80);
      for (int t = 0; t < 5; t++) begin
         tick();
         tests++;
         if (s_rv !== 1'b1 || s_y !== hy || s_id !== hid || s_ready !== 4'b0) begin
            fails++;
            $display("FAIL bp_hold t=%0d: rv=%b y=%h id=%0d ready=%b, want 1/%h/%0d/0000",
                     t, s_rv, s_y, s_id, s_ready, hy, hid);
         end
      end
      rsp_rdy = 1'b1;
      tick();
      tests++;
      if (s_ready !== 4'b0) begin
         fails++;
         $display("FAIL bp_release: ready=%b, want 0000", s_ready);
      end
      tick();
      v_r = '0;
      tests++;
      if (s_hs != 0) begin
         fails++;
         $display("FAIL bp_next_grant: id=%0d, want 0", s_hs);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      rsp_rdy = 1'b1;
      set_req(2'd2, 3'd2, 8'hA5, 8'h0F);
      wait_grant(8);
      v_r = '0;
      wait_rsp(8);
      set_req(2'd2, 3'd0, 8'hFF, 8'hFF);
      wait_grant(8);
      v_r = '0;
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      tests++;
      if ({s_ready, s_rv, s_id, s_y, s_err} !== 15'h0) begin
         fails++;
         $display("FAIL rst_mid: ready=%b rv=%b id=%0d y=%h err=%b, want all 0",
                  s_ready, s_rv, s_id, s_y, s_err);
      end
      set_req(2'd1, 3'd6, 8'h0F, 8'h00);
      set_req(2'd3, 3'd7, 8'h12, 8'h34);
      tick();
      v_r = '0;
      tests++;
      if (s_hs != 1 || s_rv !== 1'b0) begin
         fails++;
         $display("FAIL rst_ptr: id=%0d rv=%b, want 1/0", s_hs, s_rv);
      end
      drain();
   endtask

   task automatic test_wrap();
      rsp_rdy = 1'b1;
      set_req(2'd3, 3'd3, 8'h0F, 8'h30);
      wait_grant(8);
      tests++;
      if (s_hs != 3) begin
         fails++;
         $display("FAIL wrap_first: id=%0d, want 3", s_hs);
      end
      set_req(2'd0, 3'd5, 8'hCC, 8'hAA);
      wait_grant(8);
      tests++;
      if (s_hs != 0) begin
         fails++;
         $display("FAIL wrap_second: id=%0d, want 0", s_hs);
      end
      wait_grant(8);
      v_r = '0;
      tests++;
      if (s_hs != 3) begin
         fails++;
         $display("FAIL wrap_third: id=%0d, want 3", s_hs);
      end
      drain();
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      grant_cyc = 0;
      rst       = 1'b1;
      rsp_rdy   = 1'b0;
      v_r       = '0;
      for (int i = 0; i < 4; i++) begin
         op_r[i] = '0;
         a_r[i]  = '0;
         b_r[i]  = '0;
      end
      test_reset();
      test_single();
      test_op_sweep();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
